// File: rtl/countdown_timer_if.sv
// Command/status bundle between the washing-machine sequencer and the interval timer.
// The sequencer side drives the interval and load strobe; the timer reports expiry and progress.
interface countdown_timer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] set;
    logic             load;
    logic             irq;
    logic             busy;
    logic [WIDTH-1:0] count;

    modport master (
        output set,
        output load,
        input  irq,
        input  busy,
        input  count
    );

    modport slave (
        input  set,
        input  load,
        output irq,
        output busy,
        output count
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counting interval timer with a built-in tick prescaler.
// A load always restarts the interval; expiry raises a one-cycle registered irq.
module countdown_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  tmr
);

    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic [PW-1:0]    presc_r;
    logic [PW-1:0]    presc_s;
    logic             irq_r;
    logic             irq_s;
    logic             busy_r;

    // Next-state logic: load outranks an expiry tick landing on the same edge.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        presc_s = presc_r;
        irq_s   = 1'b0;
        if (tmr.load) begin
            count_s = tmr.set;
            presc_s = {PW{1'b0}};
            if (tmr.set != CNT_ZERO) begin
                state_s = RUN;
            end else begin
                state_s = IDLE;
                irq_s   = 1'b1;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (presc_r == PRESC_LAST) begin
                        presc_s = {PW{1'b0}};
                        // Treating a stray zero as expiry keeps the counter from wrapping.
                        if (count_r <= CNT_ONE) begin
                            count_s = CNT_ZERO;
                            irq_s   = 1'b1;
                            state_s = IDLE;
                        end else begin
                            count_s = count_r - CNT_ONE;
                        end
                    end else begin
                        presc_s = presc_r + PW'(1);
                    end
                end
                IDLE: begin
                    presc_s = {PW{1'b0}};
                    count_s = count_r;
                end
                default: begin
                    state_s = IDLE;
                    count_s = CNT_ZERO;
                    presc_s = {PW{1'b0}};
                end
            endcase
        end
    end

    // State, counter, prescaler and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            presc_r <= {PW{1'b0}};
            irq_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            presc_r <= presc_s;
            irq_r   <= irq_s;
            busy_r  <= (state_s == RUN);
        end
    end

    assign tmr.irq   = irq_r;
    assign tmr.busy  = busy_r;
    assign tmr.count = count_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_countdown_timer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    countdown_timer_if #(.WIDTH(16)) if1 ();
    countdown_timer_if #(.WIDTH(16)) if4 ();

    countdown_timer #(.WIDTH(16), .PRESCALE(1)) u_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (if1.slave)
    );

    countdown_timer #(.WIDTH(16), .PRESCALE(4)) u_p4 (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_p1(input string tag, input int c, input int b, input int q);
        check({tag, ".count"}, int'(if1.count), c);
        check({tag, ".busy"},  int'(if1.busy),  b);
        check({tag, ".irq"},   int'(if1.irq),   q);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        if1.set  = 16'd0;
        if1.load = 1'b0;
        if4.set  = 16'd0;
        if4.load = 1'b0;

        // Reset held for two cycles
        step();
        step();
        check_p1("reset_p1", 0, 0, 0);
        check("reset_p4.count", int'(if4.count), 0);
        check("reset_p4.busy",  int'(if4.busy),  0);
        check("reset_p4.irq",   int'(if4.irq),   0);
        rst_n = 1'b1;
        step();
        check_p1("idle_after_reset", 0, 0, 0);

        // Basic countdown of 7
        if1.set  = 16'd7;
        if1.load = 1'b1;
        step();
        if1.load = 1'b0;
        if1.set  = 16'd99;
        check_p1("basic_e0", 7, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_p1("basic_run", 7 - k, (k < 7) ? 1 : 0, (k == 7) ? 1 : 0);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            check_p1("basic_quiet", 0, 0, 0);
        end

        // Restart after 3 ticks with 5
        if1.set  = 16'd7;
        if1.load = 1'b1;
        step();
        if1.load = 1'b0;
        step();
        step();
        step();
        check_p1("restart_pre", 4, 1, 0);
        if1.set  = 16'd5;
        if1.load = 1'b1;
        step();
        if1.load = 1'b0;
        check_p1("restart_e0", 5, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_p1("restart_run", 5 - k, (k < 5) ? 1 : 0, (k == 5) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check_p1("restart_quiet", 0, 0, 0);
        end

        // Load lands on the expiry edge: load wins, no irq
        if1.set  = 16'd1;
        if1.load = 1'b1;
        step();
        check_p1("collide_e0", 1, 1, 0);
        if1.set  = 16'd3;
        step();
        if1.load = 1'b0;
        check_p1("collide_reload", 3, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check_p1("collide_run", 3 - k, (k < 3) ? 1 : 0, (k == 3) ? 1 : 0);
        end

        // Zero load from idle and from run
        step();
        if1.set  = 16'd0;
        if1.load = 1'b1;
        step();
        if1.load = 1'b0;
        check_p1("zero_idle", 0, 0, 1);
        step();
        check_p1("zero_idle_after", 0, 0, 0);
        if1.set  = 16'd4;
        if1.load = 1'b1;
        step();
        check_p1("zero_run_pre", 4, 1, 0);
        if1.set  = 16'd0;
        step();
        if1.load = 1'b0;
        check_p1("zero_run", 0, 0, 1);
        step();
        check_p1("zero_run_after", 0, 0, 0);

        // Prescaler of 4 with set=3: expiry 12 edges after load
        if4.set  = 16'd3;
        if4.load = 1'b1;
        step();
        if4.load = 1'b0;
        check("p4_e0.count", int'(if4.count), 3);
        check("p4_e0.busy",  int'(if4.busy),  1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("p4_run.count", int'(if4.count), 3 - k / 4);
            check("p4_run.busy",  int'(if4.busy),  (k < 12) ? 1 : 0);
            check("p4_run.irq",   int'(if4.irq),   (k == 12) ? 1 : 0);
        end
        step();
        check("p4_quiet.irq", int'(if4.irq), 0);

        // Reset in the middle of a run
        if1.set  = 16'd10;
        if1.load = 1'b1;
        step();
        if1.load = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_p1("midrst_pre", 6, 1, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_p1("midrst", 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step();
            check_p1("midrst_quiet", 0, 0, 0);
        end

        // Reset outranks a simultaneous load
        rst_n    = 1'b0;
        if1.set  = 16'd5;
        if1.load = 1'b1;
        step();
        rst_n    = 1'b1;
        if1.load = 1'b0;
        check_p1("rst_vs_load", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting interval timer for the washing-machine controller. Software or the sequencer writes a duration into `set` and pulses `load`. The block then counts down one unit per tick and raises a single-cycle `irq` when the interval expires. Tick rate comes from a built-in clock prescaler, so one unit can be one clock or one second of a faster clock.

## Interface
- `WIDTH`, default 16: width of `set` and of the internal counter.
- `PRESCALE`, default 1: clock cycles per count tick; must be ≥ 1. Value 1 means every clock is a tick.
- Clocking: one clock; reset is synchronous and active-low.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous active-low reset.
- `set`, input, WIDTH: interval length in ticks; sampled only when `load` = 1.
- `load`, input, 1: start or restart command, sampled at the rising edge.
- `irq`, output, 1: expiry pulse, high for exactly one clock cycle.
- `busy`, output, 1: high while a countdown is in progress.
- `count`, output, WIDTH: current remaining ticks.

## Operation
- States:
  - IDLE: `busy` = 0, counter static.
  - RUN: `busy` = 1, counter decrementing.
- Reset (`rst_n` = 0 at an edge) sets: `count` = 0, prescaler = 0, `irq` = 0, `busy` = 0, state IDLE.
- `load` = 1 at an edge, in any state:
  - `count` ← `set`; prescaler ← 0.
  - If `set` ≠ 0: state ← RUN.
  - If `set` = 0: state ← IDLE and `irq` ← 1 at the same edge (immediate expiry).
- In RUN, the prescaler counts 0…PRESCALE-1. A tick occurs on the edge where the prescaler = PRESCALE-1; the prescaler then wraps to 0.
- On a tick in RUN:
  - `count` ← `count` − 1.
  - If `count` was 1: `irq` ← 1 and state ← IDLE.
- `irq` is registered. It is cleared on every edge where it is not being set.
- Load during RUN restarts the interval. A pending expiry of the old interval is discarded, so no `irq` is produced for it.
- Load and expiry tick on the same edge: load wins, so `count` ← `set` and `irq` stays 0 (unless `set` = 0).
- In IDLE, `count` holds 0 after expiry. No further `irq` is produced until the next load.
- The counter never wraps below 0.
- Reset has priority over load.

## Timing
- With PRESCALE = 1, load is sampled at edge E0 with `set` = N, N ≥ 1:
  - `count` = N after E0, then N−1 after E1, …, 0 after EN.
  - `irq` is high from EN to EN+1.
  - `busy` is high from E0 to EN.
- General PRESCALE P: `irq` rises at edge E0 + N·P.
- `set` = 0 with load at E0: `irq` is high from E0 to E1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `set` may change freely while `load` = 0.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles → `irq` = 0, `busy` = 0, `count` = 0.
- Basic countdown (P = 1): `set` = 7, load for 1 cycle at E0 → `count` 7, 6, …, 0. `irq` is high for exactly 1 cycle after E7 and never again in the next 12 cycles.
- Restart: `set` = 7, load; 3 ticks later, load again with `set` = 5 → `irq` only 5 ticks after the second load, and a single pulse.
- Zero load: `set` = 0, load → `irq` pulses on the load edge; `busy` stays 0.
- Prescaler (P = 4): `set` = 3, load at E0 → `irq` at E12; `count` decrements every 4 cycles.
- Reset mid-run: `set` = 10, load; assert `rst_n` = 0 at tick 4 → all outputs 0 and no `irq` afterwards.
